// File: rtl/axil_cfg_master.sv
// AXI4-Lite initiator: turns a single-beat request/response port into one
// outstanding AXI4-Lite read or write, with optional alignment check and a stall watchdog.
module axil_cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          ALIGN_CHECK    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        timeout_o,
  output logic        cfg_awvalid_o,
  input  logic        cfg_awready_i,
  output logic [31:0] cfg_awaddr_o,
  output logic        cfg_wvalid_o,
  input  logic        cfg_wready_i,
  output logic [31:0] cfg_wdata_o,
  output logic [3:0]  cfg_wstrb_o,
  input  logic        cfg_bvalid_i,
  output logic        cfg_bready_o,
  input  logic [1:0]  cfg_bresp_i,
  output logic        cfg_arvalid_o,
  input  logic        cfg_arready_i,
  output logic [31:0] cfg_araddr_o,
  input  logic        cfg_rvalid_i,
  output logic        cfg_rready_o,
  input  logic [31:0] cfg_rdata_i,
  input  logic [1:0]  cfg_rresp_i
);

  // Handshakes everywhere: a transfer happens on the rising edge where valid and
  // ready are both high; a valid, once raised, holds its payload until that edge.
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WAIT_B, S_RD, S_WAIT_R, S_RESP} state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [15:0] wd_q, wd_d;
  logic        tmo_q, tmo_d;
  logic        accept, misaligned, aw_hs, w_hs, bus_busy;

  assign req_ready_o   = (state_q == S_IDLE);
  assign accept        = req_valid_i && req_ready_o;
  assign misaligned    = ALIGN_CHECK && (req_addr_i[1:0] != 2'b00);

  assign cfg_awvalid_o = (state_q == S_WR) && !aw_done_q;
  assign cfg_wvalid_o  = (state_q == S_WR) && !w_done_q;
  assign cfg_bready_o  = (state_q == S_WAIT_B);
  assign cfg_arvalid_o = (state_q == S_RD);
  assign cfg_rready_o  = (state_q == S_WAIT_R);
  assign cfg_awaddr_o  = addr_q;
  assign cfg_araddr_o  = addr_q;
  assign cfg_wdata_o   = wdata_q;
  assign cfg_wstrb_o   = wstrb_q;

  assign resp_valid_o  = (state_q == S_RESP);
  assign resp_rdata_o  = rdata_q;
  assign resp_err_o    = err_q;
  assign timeout_o     = tmo_q;

  assign aw_hs    = cfg_awvalid_o && cfg_awready_i;
  assign w_hs     = cfg_wvalid_o && cfg_wready_i;
  assign bus_busy = (state_q == S_WR) || (state_q == S_WAIT_B) ||
                    (state_q == S_RD) || (state_q == S_WAIT_R);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wd_d      = wd_q;
    tmo_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (misaligned) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_write_i) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_WR: begin
        // AW and W complete independently, in either order or together.
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (cfg_bvalid_i) begin
          rdata_d = 32'd0;
          err_d   = (cfg_bresp_i != 2'b00);
          state_d = S_RESP;
        end
      end
      S_RD: begin
        if (cfg_arready_i) state_d = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (cfg_rvalid_i) begin
          rdata_d = cfg_rdata_i;
          err_d   = (cfg_rresp_i != 2'b00);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog only reports; the bus transaction keeps waiting for the slave.
    if (accept) begin
      wd_d = 16'd0;
    end else if (bus_busy && (TMO != 16'd0) && (wd_q != TMO)) begin
      wd_d  = wd_q + 16'd1;
      tmo_d = (wd_d == TMO);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wd_q      <= 16'd0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wd_q      <= wd_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: reactive AXI-Lite slave model, response scoreboard,
// a vector table of single transactions and hand-written multi-cycle sequences.
module tb_axil_cfg_master;

  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready_o, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid_o, resp_ready = 1'b1, resp_err_o, timeout_o;
  logic [31:0] resp_rdata_o;
  logic        cfg_awvalid_o, cfg_awready = 1'b0;
  logic [31:0] cfg_awaddr_o;
  logic        cfg_wvalid_o, cfg_wready = 1'b0;
  logic [31:0] cfg_wdata_o;
  logic [3:0]  cfg_wstrb_o;
  logic        cfg_bvalid = 1'b0, cfg_bready_o;
  logic [1:0]  cfg_bresp = '0;
  logic        cfg_arvalid_o, cfg_arready = 1'b0;
  logic [31:0] cfg_araddr_o;
  logic        cfg_rvalid = 1'b0, cfg_rready_o;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = '0;

  axil_cfg_master #(.TIMEOUT_CYCLES(TMO), .ALIGN_CHECK(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .timeout_o(timeout_o),
    .cfg_awvalid_o(cfg_awvalid_o), .cfg_awready_i(cfg_awready), .cfg_awaddr_o(cfg_awaddr_o),
    .cfg_wvalid_o(cfg_wvalid_o), .cfg_wready_i(cfg_wready), .cfg_wdata_o(cfg_wdata_o),
    .cfg_wstrb_o(cfg_wstrb_o),
    .cfg_bvalid_i(cfg_bvalid), .cfg_bready_o(cfg_bready_o), .cfg_bresp_i(cfg_bresp),
    .cfg_arvalid_o(cfg_arvalid_o), .cfg_arready_i(cfg_arready), .cfg_araddr_o(cfg_araddr_o),
    .cfg_rvalid_i(cfg_rvalid), .cfg_rready_o(cfg_rready_o), .cfg_rdata_i(cfg_rdata),
    .cfg_rresp_i(cfg_rresp)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  sl_bresp = '0, sl_rresp = '0;
  logic [31:0] sl_rdata = '0;
  logic [31:0] sl_awaddr = '0, sl_wdata = '0, sl_araddr = '0;
  logic [3:0]  sl_wstrb = '0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, b_fire, ar_got, r_fire, ar_seen;
  int b_hs_cnt = 0, r_hs_cnt = 0, tmo_cnt = 0, resp_cnt = 0;

  initial begin : slave
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cfg_awready = 0; cfg_wready = 0; cfg_bvalid = 0; cfg_arready = 0; cfg_rvalid = 0;
        aw_got = 0; w_got = 0; b_fire = 0; ar_got = 0; r_fire = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        continue;
      end
      if (timeout_o) tmo_cnt++;
      if (cfg_arvalid_o) ar_seen = 1;
      // B: only after both AW and W were taken
      if (b_fire) begin
        cfg_bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0; b_cnt = 0; b_hs_cnt++;
      end else if (aw_got && w_got) begin
        if (!cfg_bvalid) begin
          if (b_cnt >= b_dly) begin cfg_bvalid = 1; cfg_bresp = sl_bresp; end
          else b_cnt++;
        end
        if (cfg_bvalid && cfg_bready_o) b_fire = 1;
      end
      cfg_awready = 0;
      if (cfg_awvalid_o && !aw_got) begin
        if (aw_cnt >= aw_dly) begin
          cfg_awready = 1; aw_got = 1; sl_awaddr = cfg_awaddr_o; aw_cnt = 0;
        end else aw_cnt++;
      end
      cfg_wready = 0;
      if (cfg_wvalid_o && !w_got) begin
        if (w_cnt >= w_dly) begin
          cfg_wready = 1; w_got = 1; sl_wdata = cfg_wdata_o; sl_wstrb = cfg_wstrb_o; w_cnt = 0;
        end else w_cnt++;
      end
      // R: only after AR was taken
      if (r_fire) begin
        cfg_rvalid = 0; r_fire = 0; ar_got = 0; r_cnt = 0; r_hs_cnt++;
      end else if (ar_got) begin
        if (!cfg_rvalid) begin
          if (r_cnt >= r_dly) begin cfg_rvalid = 1; cfg_rdata = sl_rdata; cfg_rresp = sl_rresp; end
          else r_cnt++;
        end
        if (cfg_rvalid && cfg_rready_o) r_fire = 1;
      end
      cfg_arready = 0;
      if (cfg_arvalid_o && !ar_got) begin
        if (ar_cnt >= ar_dly) begin
          cfg_arready = 1; ar_got = 1; sl_araddr = cfg_araddr_o; ar_cnt = 0;
        end else ar_cnt++;
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [32:0] exp_e;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid_o && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_e = exp_q.pop_front();
          check("resp_rdata", resp_rdata_o, exp_e[31:0]);
          check("resp_err", resp_err_o, exp_e[32]);
        end
        resp_cnt++;
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n = 0;
    req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1;
    while (!req_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_wait", req_ready_o, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 100) begin @(posedge clk); #1; n++; end
    check("resp_arrived", 64'(resp_cnt >= target), 64'd1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] srdata;
    logic [1:0]  sresp;
    int          d_a;      // AW or AR delay
    int          d_w;
    int          d_r;      // B or R delay
    logic        local_err;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    int base, b0, r0, n;
    vecs[0] = '{1'b1, 32'h04, 32'h11223344, 4'hF, 32'h0, 2'b00, 0, 0, 0, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 32'h0, 2'b10, 0, 2, 0, 1'b0, 32'h0, 1'b1};
    vecs[2] = '{1'b1, 32'h40, 32'h0BADF00D, 4'hC, 32'h0, 2'b00, 1, 1, 1, 1'b0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 32'h0C, 32'h0, 4'h0, 32'h12345678, 2'b00, 0, 0, 0, 1'b0, 32'h12345678, 1'b0};
    vecs[4] = '{1'b0, 32'h100, 32'h0, 4'h0, 32'hA5A5A5A5, 2'b11, 2, 0, 1, 1'b0, 32'hA5A5A5A5, 1'b1};
    vecs[5] = '{1'b1, 32'h06, 32'h55555555, 4'hF, 32'h0, 2'b00, 0, 0, 0, 1'b1, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 32'h21, 32'h0, 4'h0, 32'hFFFFFFFF, 2'b00, 0, 0, 0, 1'b1, 32'h0, 1'b1};

    // reset state
    cycles(3);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_outputs", {cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o, cfg_arvalid_o,
                          cfg_rready_o, resp_valid_o, resp_err_o, timeout_o}, 8'h00);
    check("rst_rdata", resp_rdata_o, 32'h0);
    rst_n = 1;
    cycles(2);

    // table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      aw_dly = vecs[i].d_a; ar_dly = vecs[i].d_a; w_dly = vecs[i].d_w;
      b_dly = vecs[i].d_r;  r_dly = vecs[i].d_r;
      sl_bresp = vecs[i].sresp; sl_rresp = vecs[i].sresp; sl_rdata = vecs[i].srdata;
      base = resp_cnt; b0 = b_hs_cnt; r0 = r_hs_cnt; ar_seen = 0;
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
      send_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      wait_resp(base + 1);
      cycles(1);
      if (vecs[i].local_err) begin
        check("vec_no_bus", {ar_seen, 8'(b_hs_cnt - b0), 8'(r_hs_cnt - r0)}, 17'h0);
      end else if (vecs[i].wr) begin
        check("vec_awaddr", sl_awaddr, vecs[i].addr);
        check("vec_wdata", {sl_wstrb, sl_wdata}, {vecs[i].wstrb, vecs[i].wdata});
        check("vec_b_count", 64'(b_hs_cnt - b0), 64'd1);
      end else begin
        check("vec_araddr", sl_araddr, vecs[i].addr);
        check("vec_r_count", 64'(r_hs_cnt - r0), 64'd1);
      end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    sl_bresp = 0; sl_rresp = 0;

    // minimum-latency write
    base = resp_cnt;
    exp_q.push_back({1'b0, 32'h0});
    send_req(1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
    check("t1_aw_w_at1", {cfg_awvalid_o, cfg_wvalid_o}, 2'b11);
    check("t1_addr_data", {cfg_awaddr_o, cfg_wdata_o}, {32'h08, 32'hDEADBEEF});
    cycles(1);
    check("t1_bready_at2", {cfg_bready_o, cfg_awvalid_o, cfg_wvalid_o}, 3'b100);
    cycles(1);
    check("t1_resp_at3", resp_valid_o, 1);
    wait_resp(base + 1);

    // AW delayed, W immediate
    aw_dly = 3;
    base = resp_cnt; b0 = b_hs_cnt;
    exp_q.push_back({1'b0, 32'h0});
    send_req(1'b1, 32'h0C, 32'h01020304, 4'h5);
    check("t2_c1", {cfg_awvalid_o, cfg_wvalid_o}, 2'b11);
    cycles(1);
    check("t2_c2", {cfg_awvalid_o, cfg_wvalid_o}, 2'b10);
    cycles(2);
    check("t2_c4", {cfg_awvalid_o, cfg_awaddr_o}, {1'b1, 32'h0C});
    cycles(1);
    check("t2_c5", cfg_awvalid_o, 0);
    wait_resp(base + 1);
    cycles(3);
    check("t2_single_b", 64'(b_hs_cnt - b0), 64'd1);
    check("t2_single_resp", 64'(resp_cnt - base), 64'd1);
    aw_dly = 0;

    // read with SLVERR, response held off
    sl_rdata = 32'h5A; sl_rresp = 2'b10; resp_ready = 0;
    base = resp_cnt;
    exp_q.push_back({1'b1, 32'h5A});
    send_req(1'b0, 32'h10, 32'h0, 4'h0);
    n = 0;
    while (!resp_valid_o && n < 20) begin cycles(1); n++; end
    for (int k = 0; k < 5; k++) begin
      check("t3_hold", {resp_valid_o, resp_err_o, resp_rdata_o}, {1'b1, 1'b1, 32'h5A});
      cycles(1);
    end
    resp_ready = 1;
    wait_resp(base + 1);
    check("t3_rdata_kept", {resp_valid_o, resp_rdata_o}, {1'b0, 32'h5A});
    sl_rresp = 0;

    // misaligned read
    ar_seen = 0; base = resp_cnt;
    exp_q.push_back({1'b1, 32'h0});
    send_req(1'b0, 32'h13, 32'h0, 4'h0);
    n = 1;
    while (!resp_valid_o && n < 2) begin cycles(1); n++; end
    check("t4_resp_latency", resp_valid_o, 1);
    wait_resp(base + 1);
    check("t4_no_arvalid", ar_seen, 0);

    // watchdog: slow B
    check("t5_no_early_tmo", 64'(tmo_cnt), 64'd0);
    b_dly = 20; base = resp_cnt;
    exp_q.push_back({1'b0, 32'h0});
    send_req(1'b1, 32'h80, 32'h77777777, 4'hF);
    wait_resp(base + 1);
    check("t5_tmo_one_pulse", 64'(tmo_cnt), 64'd1);
    b_dly = 0;

    // reset while waiting for R
    r_dly = 50;
    send_req(1'b0, 32'h30, 32'h0, 4'h0);
    n = 0;
    while (!cfg_rready_o && n < 20) begin cycles(1); n++; end
    check("t6_in_wait_r", cfg_rready_o, 1);
    rst_n = 0;
    #1;
    check("t6_rst_outputs", {cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o, cfg_arvalid_o,
                             cfg_rready_o, resp_valid_o, timeout_o}, 7'h00);
    cycles(3);
    rst_n = 1;
    r_dly = 0;
    cycles(2);
    check("t6_req_ready", {req_ready_o, resp_valid_o}, 2'b10);

    // normal read after reset
    sl_rdata = 32'h0F0F1234; base = resp_cnt;
    exp_q.push_back({1'b0, 32'h0F0F1234});
    send_req(1'b0, 32'h44, 32'h0, 4'h0);
    wait_resp(base + 1);

    cycles(2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : global_limit
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
